// File: rtl/fetch_controller_pkg.sv
// Shared types and constants for the instruction fetch controller and its queue.
package fetch_controller_pkg;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int          INST_WIDTH  = 32;
  localparam int          ENTRY_WIDTH = 32 + INST_WIDTH;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0]           pc;
    logic [INST_WIDTH-1:0] instr;
  } fetch_entry_t;

  function automatic logic pc_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_controller_queue.sv
// Synchronous FIFO holding fetched {pc, instr} entries; supports flush and
// push/pop in the same cycle, including a push into a full queue that is popping.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = fetch_controller_pkg::ENTRY_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic             not_empty,
  output logic             full
);

  localparam int             PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int             CW      = PW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign not_empty = (count_q != '0);
  assign full      = (count_q == DEPTH_C);
  assign do_pop    = pop & not_empty;
  assign do_push   = push & (!full | do_pop);

  // Empty queue presents zeros so the head outputs are defined without resetting storage.
  assign head_data = not_empty ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, reads the ROM, queues words for
// decode and handles redirects and fetch faults.
module fetch_controller #(
  parameter logic [31:0] RESET_PC    = fetch_controller_pkg::RESET_PC,
  parameter int          QUEUE_DEPTH = 2,
  parameter int          ROM_BYTES   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] inst_count
);

  import fetch_controller_pkg::*;

  localparam logic [31:0] ROM_END = 32'(ROM_BYTES);

  state_e       state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  fault_pc_q, fault_pc_d;
  logic [31:0]  inst_count_q, inst_count_d;
  logic         q_valid;
  logic         q_full;
  logic         pop;
  logic         push;
  logic         flush;
  logic         in_rom;
  logic         redirect_act;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

  assign imem_address = fetch_pc_q;
  assign in_rom       = (fetch_pc_q < ROM_END);
  assign redirect_act = redirect && (state_q != ST_FAULT);
  assign flush        = redirect_act;
  assign pop          = q_valid & inst_ready;
  assign push         = (state_q == ST_FETCH) && enable && !redirect && in_rom
                        && (!q_full || pop);

  assign push_entry.pc    = fetch_pc_q;
  assign push_entry.instr = imem_instruction;

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (ENTRY_WIDTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .push_data (push_entry),
    .head_data (head_entry),
    .not_empty (q_valid),
    .full      (q_full)
  );

  // Redirect outranks everything except the terminal fault state.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    fault_pc_d   = fault_pc_q;
    inst_count_d = inst_count_q + 32'(pop);
    if (redirect_act) begin
      if (pc_aligned(redirect_target)) begin
        fetch_pc_d = redirect_target;
        state_d    = ST_FETCH;
      end else begin
        state_d    = ST_FAULT;
        fault_pc_d = redirect_target;
      end
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (enable && !in_rom) begin
            state_d    = ST_FAULT;
            fault_pc_d = fetch_pc_q;
          end else begin
            if (push) begin
              fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (q_full && !pop) begin
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (pop) begin
            state_d = ST_FETCH;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FETCH;
      fetch_pc_q   <= RESET_PC;
      fault_pc_q   <= '0;
      inst_count_q <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      fault_pc_q   <= fault_pc_d;
      inst_count_q <= inst_count_d;
    end
  end

  assign inst_valid = q_valid;
  assign inst_data  = head_entry.instr;
  assign inst_pc    = head_entry.pc;
  assign fault      = (state_q == ST_FAULT);
  assign fault_pc   = fault_pc_q;
  assign inst_count = inst_count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: a full-size ROM instance and a 16-byte
// ROM instance for the end-of-ROM fault.
module tb_fetch_controller;

  import fetch_controller_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable, redirect, inst_ready;
  logic [31:0] redirect_target;
  logic [31:0] imem_address, imem_instruction;
  logic        inst_valid, fault;
  logic [31:0] inst_data, inst_pc, fault_pc, inst_count;

  logic        s_reset, s_enable, s_redirect, s_ready;
  logic [31:0] s_target;
  logic [31:0] s_imem_address, s_imem_instruction;
  logic        s_valid, s_fault;
  logic [31:0] s_data, s_pc, s_fault_pc, s_count;

  int checks = 0;
  int errors = 0;

  fetch_entry_t exp_q[$];
  fetch_entry_t exp2_q[$];

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    if (pc == 32'h0) return 32'h0000_1503;
    if (pc == 32'h4) return 32'h0040_1583;
    return 32'hA000_0000 | pc;
  endfunction

  assign imem_instruction   = rom_word({22'd0, imem_address[9:2], 2'b00});
  assign s_imem_instruction = rom_word({22'd0, s_imem_address[9:2], 2'b00});

  fetch_controller #(.RESET_PC(32'h0), .QUEUE_DEPTH(2), .ROM_BYTES(1024)) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .redirect         (redirect),
    .redirect_target  (redirect_target),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .inst_data        (inst_data),
    .inst_pc          (inst_pc),
    .fault            (fault),
    .fault_pc         (fault_pc),
    .inst_count       (inst_count)
  );

  fetch_controller #(.RESET_PC(32'h0), .QUEUE_DEPTH(2), .ROM_BYTES(16)) dut_small (
    .clk              (clk),
    .reset            (s_reset),
    .enable           (s_enable),
    .imem_address     (s_imem_address),
    .imem_instruction (s_imem_instruction),
    .redirect         (s_redirect),
    .redirect_target  (s_target),
    .inst_valid       (s_valid),
    .inst_ready       (s_ready),
    .inst_data        (s_data),
    .inst_pc          (s_pc),
    .fault            (s_fault),
    .fault_pc         (s_fault_pc),
    .inst_count       (s_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_main(input logic [31:0] pc);
    fetch_entry_t e;
    e.pc    = pc;
    e.instr = rom_word(pc);
    exp_q.push_back(e);
  endtask

  task automatic expect_small(input logic [31:0] pc);
    fetch_entry_t e;
    e.pc    = pc;
    e.instr = rom_word(pc);
    exp2_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every handshake pops one expected entry.
  always @(negedge clk) begin
    fetch_entry_t e;
    if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL main_unexpected_pop: got pc %h expected no handshake", inst_pc);
      end else begin
        e = exp_q.pop_front();
        chk("main_pop_pc", inst_pc, e.pc);
        chk("main_pop_data", inst_data, e.instr);
      end
    end
  end

  always @(negedge clk) begin
    fetch_entry_t e;
    if (s_valid === 1'b1 && s_ready === 1'b1) begin
      if (exp2_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL small_unexpected_pop: got pc %h expected no handshake", s_pc);
      end else begin
        e = exp2_q.pop_front();
        chk("small_pop_pc", s_pc, e.pc);
        chk("small_pop_data", s_data, e.instr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; redirect = 1'b0; redirect_target = '0; inst_ready = 1'b1;
    s_reset = 1'b1; s_enable = 1'b1; s_redirect = 1'b0; s_target = '0; s_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_data", inst_data, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    chk("rst_count", inst_count, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_fault_pc", fault_pc, 32'd0);
    chk("rst_imem", imem_address, 32'd0);

    // Streaming, then redirect with two entries queued, then misaligned redirect.
    expect_main(32'h0); expect_main(32'h4); expect_main(32'h8);
    expect_main(32'h18); expect_main(32'h1C);
    tick(); reset = 1'b0;
    tick();
    tick();
    tick(); inst_ready = 1'b0;
    @(negedge clk);
    chk("count_after_two", inst_count, 32'd2);
    chk("head_pc_c3", inst_pc, 32'h8);
    tick(); inst_ready = 1'b1; redirect = 1'b1; redirect_target = 32'h18;
    @(negedge clk);
    chk("head_before_redirect", inst_pc, 32'h8);
    tick(); redirect = 1'b0;
    @(negedge clk);
    chk("redir_flush_valid", 32'(inst_valid), 32'd0);
    chk("redir_count", inst_count, 32'd3);
    chk("redir_imem", imem_address, 32'h18);
    tick();
    tick(); redirect = 1'b1; redirect_target = 32'h1A;
    tick(); redirect_target = 32'h0;
    @(negedge clk);
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_fault_pc", fault_pc, 32'h1A);
    chk("mis_valid", 32'(inst_valid), 32'd0);
    chk("mis_count", inst_count, 32'd5);
    tick(); redirect = 1'b0;
    @(negedge clk);
    chk("fault_sticky", 32'(fault), 32'd1);
    chk("fault_pc_held", fault_pc, 32'h1A);
    chk("fault_redirect_ignored", imem_address, 32'h20);

    // Reset clears the fault; then backpressure into HOLD and release.
    tick(); reset = 1'b1; inst_ready = 1'b0;
    tick(); reset = 1'b0;
    @(negedge clk);
    chk("clr_valid", 32'(inst_valid), 32'd0);
    chk("clr_data", inst_data, 32'd0);
    chk("clr_count", inst_count, 32'd0);
    chk("clr_imem", imem_address, 32'd0);
    chk("clr_fault", 32'(fault), 32'd0);
    chk("clr_fault_pc", fault_pc, 32'd0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      @(negedge clk);
      chk("stall_valid", 32'(inst_valid), 32'd1);
      chk("stall_pc", inst_pc, 32'h0);
      chk("stall_data", inst_data, 32'h0000_1503);
    end
    chk("stall_imem", imem_address, 32'h8);
    chk("stall_state_hold", 32'(dut.state_q), 32'(ST_HOLD));
    expect_main(32'h0); expect_main(32'h4); expect_main(32'h8); expect_main(32'hC);
    for (int c = 5; c <= 8; c++) begin
      tick();
      inst_ready = 1'b1;
      @(negedge clk);
      chk("stream_no_gap", 32'(inst_valid), 32'd1);
    end
    tick(); inst_ready = 1'b0;
    tick();
    @(negedge clk);
    chk("refill_valid", 32'(inst_valid), 32'd1);
    chk("refill_pc", inst_pc, 32'h10);
    chk("refill_count", inst_count, 32'd4);

    // Reset mid-stream with a full queue.
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(inst_valid), 32'd0);
    chk("mid_rst_count", inst_count, 32'd0);
    chk("mid_rst_imem", imem_address, 32'h0);
    chk("mid_rst_fault", 32'(fault), 32'd0);

    // End-of-ROM fault on the 16-byte instance.
    expect_small(32'h0); expect_small(32'h4); expect_small(32'h8); expect_small(32'hC);
    tick(); s_reset = 1'b0;
    @(negedge clk);
    chk("eor_c0_valid", 32'(s_valid), 32'd0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      @(negedge clk);
      chk("eor_stream_valid", 32'(s_valid), 32'd1);
      chk("eor_no_fault_yet", 32'(s_fault), 32'd0);
    end
    tick();
    @(negedge clk);
    chk("eor_fault", 32'(s_fault), 32'd1);
    chk("eor_fault_pc", s_fault_pc, 32'h10);
    chk("eor_valid", 32'(s_valid), 32'd0);
    chk("eor_count", s_count, 32'd4);
    chk("eor_imem", s_imem_address, 32'h10);
    tick();
    tick();
    @(negedge clk);
    chk("eor_fault_sticky", 32'(s_fault), 32'd1);
    chk("eor_valid_low", 32'(s_valid), 32'd0);

    chk("main_sb_drained", 32'(exp_q.size()), 32'd0);
    chk("small_sb_drained", 32'(exp2_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
